// File: rtl/count_monitor_if.sv
// count_monitor_if: the counter-observation bus shared by a step counter and its monitor.
//   mode      counter direction, 1 up / 0 down
//   cnt       signed counter value
//   zone      hysteresis zone: 00 MID, 01 HIGH, 10 LOW
//   step_err  1-cycle pulse, illegal step size
//   inv_err   1-cycle pulse, forbidden value seen
//   wrap_evt  1-cycle pulse, counter wrapped
//   min_val   signed minimum of valid samples
//   max_val   signed maximum of valid samples
//   err_cnt   saturating count of error cycles
// master: the side that owns the counter and consumes status.
// slave:  the monitor, which samples the counter and drives status.
interface count_monitor_if #(
    parameter int unsigned Width = 10,
    parameter int unsigned EvtW  = 8
);
    logic                    mode;
    logic signed [Width-1:0] cnt;
    logic [1:0]              zone;
    logic                    step_err;
    logic                    inv_err;
    logic                    wrap_evt;
    logic signed [Width-1:0] min_val;
    logic signed [Width-1:0] max_val;
    logic [EvtW-1:0]         err_cnt;

    modport master (
        output mode, cnt,
        input  zone, step_err, inv_err, wrap_evt, min_val, max_val, err_cnt
    );

    modport slave (
        input  mode, cnt,
        output zone, step_err, inv_err, wrap_evt, min_val, max_val, err_cnt
    );
endinterface

// File: rtl/count_monitor.sv
// count_monitor: passive observer of a signed up/down step counter.
// Every non-reset cycle it samples cnt/mode, checks the transition from the previous sample
// against the step rules, tracks HIGH/LOW hysteresis zones, records min/max and keeps a
// saturating error count. It never drives the counter.
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset; discards all history
//   bus_io  count_monitor_if.slave: mode/cnt in, zone/pulses/min/max/err_cnt out
// Width and EvtW must match the parameters of the connected interface.
module count_monitor #(
    parameter int unsigned Width  = 10,
    parameter int          UpStep = 5,
    parameter int          DnStep = 9,
    parameter int          Inv    = -11,
    parameter int          HiSet  = 200,
    parameter int          HiClr  = 180,
    parameter int          LoSet  = -200,
    parameter int          LoClr  = -180,
    parameter int unsigned EvtW   = 8
) (
    input logic            clk,
    input logic            rst,
    count_monitor_if.slave bus_io
);

    // Two guard bits so prev + step and cnt - prev never overflow.
    localparam int unsigned XW = Width + 2;
    typedef logic signed [XW-1:0] ext_t;

    localparam ext_t UpX    = ext_t'(UpStep);
    localparam ext_t DnX    = ext_t'(-DnStep);
    localparam ext_t InvX   = ext_t'(Inv);
    localparam ext_t HiSetX = ext_t'(HiSet);
    localparam ext_t HiClrX = ext_t'(HiClr);
    localparam ext_t LoSetX = ext_t'(LoSet);
    localparam ext_t LoClrX = ext_t'(LoClr);

    localparam logic signed [Width-1:0] MinInit = {1'b0, {(Width-1){1'b1}}};
    localparam logic signed [Width-1:0] MaxInit = {1'b1, {(Width-1){1'b0}}};
    localparam logic [EvtW-1:0]         ErrMax  = '1;

    typedef enum logic [1:0] {
        StMid  = 2'b00,
        StHigh = 2'b01,
        StLow  = 2'b10
    } zone_e;

    zone_e zone_q, zone_d;

    logic                    valid_q, valid_d;
    logic signed [Width-1:0] prev_cnt_q, prev_cnt_d;
    logic                    prev_mode_q, prev_mode_d;
    logic                    step_err_q, step_err_d;
    logic                    inv_err_q, inv_err_d;
    logic                    wrap_evt_q, wrap_evt_d;
    logic signed [Width-1:0] min_q, min_d;
    logic signed [Width-1:0] max_q, max_d;
    logic [EvtW-1:0]         err_cnt_q, err_cnt_d;

    ext_t cnt_x, prev_x, delta, exp_base, exp_step;
    logic wrap, step_bad, is_inv;

    // Transition analysis in extended signed arithmetic.
    always_comb begin
        cnt_x    = {{2{bus_io.cnt[Width-1]}}, bus_io.cnt};
        prev_x   = {{2{prev_cnt_q[Width-1]}}, prev_cnt_q};
        delta    = cnt_x - prev_x;
        exp_base = prev_mode_q ? UpX : DnX;
        // The counter doubles its step to jump over the forbidden value.
        exp_step = ((prev_x + exp_base) == InvX) ? (exp_base + exp_base) : exp_base;
        wrap     = prev_mode_q ? (cnt_x < prev_x) : (cnt_x > prev_x);
        step_bad = (delta != exp_step);
        is_inv   = (cnt_x == InvX);
    end

    // Datapath next state.
    always_comb begin
        valid_d     = 1'b1;
        prev_cnt_d  = bus_io.cnt;
        prev_mode_d = bus_io.mode;
        // Wrap outranks the step check; the priming sample runs neither.
        wrap_evt_d  = valid_q & wrap;
        step_err_d  = valid_q & ~wrap & step_bad;
        inv_err_d   = is_inv;
        err_cnt_d   = err_cnt_q;
        if ((step_err_d || inv_err_d) && (err_cnt_q != ErrMax)) begin
            err_cnt_d = err_cnt_q + EvtW'(1);
        end
        min_d = (bus_io.cnt < min_q) ? bus_io.cnt : min_q;
        max_d = (bus_io.cnt > max_q) ? bus_io.cnt : max_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            prev_cnt_q  <= '0;
            prev_mode_q <= 1'b0;
            step_err_q  <= 1'b0;
            inv_err_q   <= 1'b0;
            wrap_evt_q  <= 1'b0;
            min_q       <= MinInit;
            max_q       <= MaxInit;
            err_cnt_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            prev_cnt_q  <= prev_cnt_d;
            prev_mode_q <= prev_mode_d;
            step_err_q  <= step_err_d;
            inv_err_q   <= inv_err_d;
            wrap_evt_q  <= wrap_evt_d;
            min_q       <= min_d;
            max_q       <= max_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Zone FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            zone_q <= StMid;
        end else begin
            zone_q <= zone_d;
        end
    end

    // Zone FSM: next state. Set thresholds win from any state, so a wrap may jump HIGH<->LOW.
    always_comb begin
        zone_d = zone_q;
        if (cnt_x >= HiSetX) begin
            zone_d = StHigh;
        end else if (cnt_x <= LoSetX) begin
            zone_d = StLow;
        end else begin
            unique case (zone_q)
                StHigh:  if (cnt_x <= HiClrX) zone_d = StMid;
                StLow:   if (cnt_x >= LoClrX) zone_d = StMid;
                default: zone_d = StMid;
            endcase
        end
    end

    // Outputs: all straight from registers.
    always_comb begin
        bus_io.zone     = zone_q;
        bus_io.step_err = step_err_q;
        bus_io.inv_err  = inv_err_q;
        bus_io.wrap_evt = wrap_evt_q;
        bus_io.min_val  = min_q;
        bus_io.max_val  = max_q;
        bus_io.err_cnt  = err_cnt_q;
    end

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor. Two instances see identical stimulus: one with the
// default 8-bit error counter and one with a 2-bit counter to exercise saturation.
module tb_count_monitor;

    logic              clk;
    logic              rst;
    logic              mode_drv;
    logic signed [9:0] cnt_drv;

    int n_cmp;
    int n_bad;

    count_monitor_if #(.Width(10), .EvtW(8)) bus8 ();
    count_monitor_if #(.Width(10), .EvtW(2)) bus2 ();

    assign bus8.mode = mode_drv;
    assign bus8.cnt  = cnt_drv;
    assign bus2.mode = mode_drv;
    assign bus2.cnt  = cnt_drv;

    count_monitor #(.Width(10), .EvtW(8)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus8)
    );

    count_monitor #(.Width(10), .EvtW(2)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
        end
    endtask

    // Present one sample, let the edge capture it, then settle past the edge.
    task automatic sample(input logic m, input int c);
        mode_drv = m;
        cnt_drv  = c[9:0];
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int t2_seq [5] = '{-26, -21, -16, -6, -1};
    int c;

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        mode_drv = 1'b0;
        cnt_drv  = -10'sd50;

        // T1: reset state
        do_reset(2);
        check_val("t1_zone", bus8.zone, 0);
        check_val("t1_step", bus8.step_err, 0);
        check_val("t1_inv", bus8.inv_err, 0);
        check_val("t1_wrap", bus8.wrap_evt, 0);
        check_val("t1_err8", bus8.err_cnt, 0);
        check_val("t1_err2", bus2.err_cnt, 0);
        check_val("t1_min", bus8.min_val, 511);
        check_val("t1_max", bus8.max_val, -512);

        // T2: up steps including the jump over -11
        foreach (t2_seq[i]) begin
            sample(1'b1, t2_seq[i]);
            check_val("t2_step", bus8.step_err, 0);
            check_val("t2_wrap", bus8.wrap_evt, 0);
        end
        check_val("t2_min", bus8.min_val, -26);
        check_val("t2_max", bus8.max_val, -1);
        check_val("t2_err", bus8.err_cnt, 0);

        // T3: down steps, a wrap back up, then landing on the forbidden value
        do_reset(1);
        sample(1'b0, 7);
        check_val("t3_prime_step", bus8.step_err, 0);
        sample(1'b0, -2);
        check_val("t3_step_a", bus8.step_err, 0);
        sample(1'b0, -20);
        check_val("t3_step_dbl", bus8.step_err, 0);
        check_val("t3_inv_none", bus8.inv_err, 0);
        sample(1'b0, -2);
        check_val("t3_wrap", bus8.wrap_evt, 1);
        check_val("t3_wrap_step", bus8.step_err, 0);
        sample(1'b0, -11);
        check_val("t3_inv", bus8.inv_err, 1);
        check_val("t3_step_bad", bus8.step_err, 1);
        check_val("t3_wrap_clr", bus8.wrap_evt, 0);
        check_val("t3_err", bus8.err_cnt, 1);
        check_val("t3_min", bus8.min_val, -20);
        check_val("t3_max", bus8.max_val, 7);

        // T4: HIGH hysteresis
        do_reset(1);
        sample(1'b1, 195);
        check_val("t4_z195", bus8.zone, 0);
        sample(1'b1, 200);
        check_val("t4_z200", bus8.zone, 1);
        sample(1'b1, 185);
        check_val("t4_z185", bus8.zone, 1);
        sample(1'b1, 180);
        check_val("t4_z180", bus8.zone, 0);

        // T5: wrap from HIGH straight into LOW
        do_reset(1);
        sample(1'b1, 230);
        check_val("t5_z230", bus8.zone, 1);
        sample(1'b1, 235);
        check_val("t5_step235", bus8.step_err, 0);
        check_val("t5_wrap235", bus8.wrap_evt, 0);
        sample(1'b1, -230);
        check_val("t5_wrap", bus8.wrap_evt, 1);
        check_val("t5_wrap_step", bus8.step_err, 0);
        check_val("t5_zlow", bus8.zone, 2);
        sample(1'b1, -225);
        check_val("t5_wrap_pulse", bus8.wrap_evt, 0);
        check_val("t5_step225", bus8.step_err, 0);
        check_val("t5_zhold", bus8.zone, 2);

        // T6: five illegal steps, saturation at 3 on the 2-bit counter, then mid-run reset
        c = -225;
        for (int i = 1; i <= 5; i++) begin
            c = c + 15;
            sample(1'b1, c);
            check_val("t6_step", bus8.step_err, 1);
            check_val("t6_err8", bus8.err_cnt, i);
            check_val("t6_err2", bus2.err_cnt, (i > 3) ? 3 : i);
        end
        do_reset(1);
        check_val("t6_rst_err8", bus8.err_cnt, 0);
        check_val("t6_rst_err2", bus2.err_cnt, 0);
        check_val("t6_rst_zone", bus8.zone, 0);
        check_val("t6_rst_min", bus8.min_val, 511);
        sample(1'b1, -100);
        check_val("t6_prime_step", bus8.step_err, 0);
        check_val("t6_prime_wrap", bus8.wrap_evt, 0);
        sample(1'b1, -95);
        check_val("t6_ok_step", bus8.step_err, 0);
        sample(1'b1, -80);
        check_val("t6_bad_step", bus8.step_err, 1);
        check_val("t6_err_after", bus8.err_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
